// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage. Keeps the fetch PC, issues
//               single-outstanding word reads, buffers returned words with
//               their PCs in a 2-entry FIFO and hands them to decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h80020000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        decode_ready,
  output logic [31:0] insn,
  output logic [31:0] pc,
  output logic        enable_decode
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [31:0] fifo_insn_q [2];
  logic [31:0] fifo_pc_q   [2];
  logic [31:0] insn_q, insn_d;
  logic [31:0] pc_q, pc_d;
  logic        enable_decode_q, enable_decode_d;

  logic w_pop;
  logic w_issue;
  logic w_push;

  // The count used for issue is the pre-pop value, so a full FIFO never
  // issues even if decode drains an entry in the same cycle. Held low while
  // in reset so the request output is quiet during reset.
  assign w_pop   = enable_decode_q & decode_ready;
  assign w_issue = reset_n & (state_q == S_IDLE) & ~redirect & (count_q != 2'd2);
  assign w_push  = (state_q == S_WAIT) & imem_rvalid & ~redirect;

  assign imem_req      = w_issue;
  assign imem_addr     = fetch_pc_q;
  assign insn          = insn_q;
  assign pc            = pc_q;
  assign enable_decode = enable_decode_q;

  // Next-state logic for the fetch FSM, FIFO bookkeeping and decode outputs.
  always_comb begin
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    req_pc_d        = req_pc_q;
    count_d         = count_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    insn_d          = insn_q;
    pc_d            = pc_q;
    enable_decode_d = 1'b0;

    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      // A response arriving together with the redirect completes the
      // outstanding read (and is dropped), so there is nothing left to flush.
      if (state_q != S_IDLE && imem_rvalid) begin
        state_d = S_IDLE;
      end else if (state_q == S_WAIT) begin
        state_d = S_FLUSH;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_issue) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_STEP;
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) state_d = S_IDLE;
        end
        S_FLUSH: begin
          if (imem_rvalid) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      count_d  = count_q + {1'b0, w_push} - {1'b0, w_pop};
      rd_ptr_d = rd_ptr_q ^ w_pop;
      wr_ptr_d = wr_ptr_q ^ w_push;
    end

    // Registered outputs show the head entry of the next FIFO state; a word
    // pushed into the new head slot bypasses storage to keep latency at 1.
    if (count_d != 2'd0) begin
      enable_decode_d = 1'b1;
      if (w_push && (wr_ptr_q == rd_ptr_d)) begin
        insn_d = imem_rdata;
        pc_d   = req_pc_q;
      end else begin
        insn_d = fifo_insn_q[rd_ptr_d];
        pc_d   = fifo_pc_q[rd_ptr_d];
      end
    end
  end

  // State, FIFO storage and output registers with asynchronous reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      fetch_pc_q      <= RESET_PC;
      req_pc_q        <= 32'd0;
      count_q         <= 2'd0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      fifo_insn_q[0]  <= 32'd0;
      fifo_insn_q[1]  <= 32'd0;
      fifo_pc_q[0]    <= 32'd0;
      fifo_pc_q[1]    <= 32'd0;
      insn_q          <= 32'd0;
      pc_q            <= 32'd0;
      enable_decode_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      fetch_pc_q      <= fetch_pc_d;
      req_pc_q        <= req_pc_d;
      count_q         <= count_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      insn_q          <= insn_d;
      pc_q            <= pc_d;
      enable_decode_q <= enable_decode_d;
      if (w_push) begin
        fifo_insn_q[wr_ptr_q] <= imem_rdata;
        fifo_pc_q[wr_ptr_q]   <= req_pc_q;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage with a memory model and a
//               queue-based reference of the decode-visible instruction stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  localparam logic [31:0] C_RESET_PC = 32'h80020000;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
  } ent_t;

  logic        clock;
  logic        reset_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        decode_ready;
  logic [31:0] insn;
  logic [31:0] pc;
  logic        enable_decode;

  fetch_stage #(
    .RESET_PC(C_RESET_PC),
    .PC_STEP (32'd4)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .imem_addr    (imem_addr),
    .imem_req     (imem_req),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .decode_ready (decode_ready),
    .insn         (insn),
    .pc           (pc),
    .enable_decode(enable_decode)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_cmp = 0;
  int n_err = 0;
  int n_req = 0;

  // memory model
  bit          mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          fixed_lat;

  // reference model of the fetch stage
  ent_t        mq[$];
  bit          outstanding;
  bit          kept;
  logic [31:0] exp_fetch;
  logic [31:0] req_pc;
  logic [31:0] shown_insn;
  logic [31:0] shown_pc;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hFFFF0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check, then advance the model.
  task automatic step(input bit rd, input logic [31:0] rpc, input bit dr, input bit stray);
    bit exp_req;
    @(negedge clock);
    redirect     = rd;
    redirect_pc  = rpc;
    decode_ready = dr;
    imem_rvalid  = 1'b0;
    imem_rdata   = $urandom;
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_of(mem_addr);
        mem_pend    = 1'b0;
      end
    end
    if (stray) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEADBEEF;
    end
    #1;
    exp_req = !outstanding && !rd && (mq.size() < 2);
    chk("enable_decode", {31'd0, enable_decode}, {31'd0, mq.size() > 0});
    chk("insn", insn, shown_insn);
    chk("pc", pc, shown_pc);
    chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    chk("imem_addr", imem_addr, exp_fetch);

    if (imem_req) begin
      mem_pend = 1'b1;
      mem_cnt  = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 3));
      mem_addr = imem_addr;
      n_req++;
    end

    if ((mq.size() > 0) && dr) void'(mq.pop_front());
    if (rd) begin
      mq.delete();
      exp_fetch = {rpc[31:2], 2'b00};
      if (outstanding) begin
        if (imem_rvalid) outstanding = 1'b0;
        else             kept        = 1'b0;
      end
    end else begin
      if (imem_rvalid && outstanding) begin
        if (kept) mq.push_back('{insn: word_of(req_pc), pc: req_pc});
        outstanding = 1'b0;
      end
      if (exp_req) begin
        outstanding = 1'b1;
        kept        = 1'b1;
        req_pc      = exp_fetch;
        exp_fetch   = exp_fetch + 32'd4;
      end
    end
    if (mq.size() > 0) begin
      shown_insn = mq[0].insn;
      shown_pc   = mq[0].pc;
    end
  endtask

  // Assert reset asynchronously in mid-cycle and check outputs before any edge.
  task automatic do_reset_async();
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_enable_decode", {31'd0, enable_decode}, 32'd0);
    chk("rst_insn", insn, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_imem_addr", imem_addr, C_RESET_PC);
    mq.delete();
    outstanding  = 1'b0;
    kept         = 1'b0;
    exp_fetch    = C_RESET_PC;
    req_pc       = 32'd0;
    shown_insn   = 32'd0;
    shown_pc     = 32'd0;
    mem_pend     = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 32'd0;
    decode_ready = 1'b0;
    imem_rvalid  = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #3 reset_n = 1'b1;
  endtask

  // Step until a request is issued, bounded to 10 cycles.
  task automatic wait_req(input string tag);
    int start;
    start = n_req;
    for (int i = 0; i < 10 && n_req == start; i++) step(1'b0, 32'd0, 1'b1, 1'b0);
    chk(tag, {31'd0, n_req != start}, 32'd1);
  endtask

  initial begin
    reset_n      = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 32'd0;
    decode_ready = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'd0;
    mem_pend     = 1'b0;
    mem_cnt      = 0;
    mem_addr     = 32'd0;
    fixed_lat    = 1;

    // Sequential fetch, latency 1, decode always ready
    do_reset_async();
    n_req = 0;
    for (int i = 0; i < 20; i++) step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("throughput_reqs", n_req, 32'd10);

    // Decode stalled: FIFO fills after exactly two requests, then drains
    do_reset_async();
    n_req = 0;
    for (int i = 0; i < 12; i++) step(1'b0, 32'd0, 1'b0, 1'b0);
    chk("stall_reqs", n_req, 32'd2);
    chk("stall_head_pc", pc, 32'h80020000);
    for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("drain_reqs", n_req, 32'd6);

    // Redirect while waiting on a slow response
    fixed_lat = 3;
    wait_req("wait_req_flush");
    step(1'b1, 32'h80021003, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 32'd0, 1'b1, 1'b0);

    // Redirect coinciding with the response
    fixed_lat = 1;
    wait_req("wait_req_same_cycle");
    step(1'b1, 32'h80030010, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 1'b1, 1'b0);

    // Address wrap at the top of the address space
    step(1'b1, 32'hFFFFFFFC, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 32'd0, 1'b1, 1'b0);

    // Randomized traffic: random latency, stalls and redirects
    fixed_lat = 0;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) == 0), $urandom, ($urandom_range(0, 2) != 0), 1'b0);
    end

    // Reset in the middle of a slow read, then a stray response
    fixed_lat = 3;
    wait_req("wait_req_reset");
    step(1'b0, 32'd0, 1'b1, 1'b0);
    do_reset_async();
    step(1'b0, 32'd0, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 32'd0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage directly upstream of the decode stage.
- Holds the fetch PC and issues single-outstanding word reads to instruction memory.
- Buffers returned words with their PCs in a 2-entry FIFO and presents them to decode on `insn`/`pc`, qualified by `enable_decode`.
- Accepts a redirect (branch/jump target) that flushes buffered and in-flight instructions.

Parameters:
- RESET_PC, 32'h80020000, fetch address loaded on reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset_n  in  1  asynchronous active-low reset.
- imem_addr  out  32  read address; valid while imem_req=1.
- imem_req  out  1  one-cycle read request pulse; memory always accepts it in the same cycle.
- imem_rvalid  in  1  read data valid; one pulse per request, at least 1 cycle after the request.
- imem_rdata  in  32  instruction word, qualified by imem_rvalid.
- redirect  in  1  load a new fetch PC and flush the pipeline.
- redirect_pc  in  32  new fetch PC; bits [1:0] are forced to 0.
- decode_ready  in  1  decode accepts the head entry this cycle.
- insn  out  32  head-entry instruction word.
- pc  out  32  head-entry instruction address.
- enable_decode  out  1  head entry valid.

Behaviour:
- Reset (async, reset_n=0):
  - fetch_pc=RESET_PC, state=IDLE, FIFO count=0.
  - enable_decode=0, insn=0, pc=0, imem_req=0, imem_addr=RESET_PC.
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; response is kept.
  - FLUSH: request outstanding; response is discarded.
- Request issue (combinational):
  - imem_req=1 iff state=IDLE && redirect=0 && count<2.
  - count is taken before this cycle's pop.
  - imem_addr=fetch_pc always.
- On issue: store req_pc=fetch_pc, fetch_pc += PC_STEP (mod 2^32; 32'hFFFFFFFC wraps to 0), IDLE->WAIT.
- WAIT + imem_rvalid: push {imem_rdata, req_pc} into the FIFO, ->IDLE. The next request issues no earlier than the following cycle.
- FLUSH + imem_rvalid: discard data, ->IDLE.
- imem_rvalid in IDLE: protocol error; ignored, no state change.
- Redirect (highest priority):
  - FIFO count->0; fetch_pc={redirect_pc[31:2],2'b00}; no request that cycle.
  - State: WAIT->FLUSH, FLUSH stays FLUSH, IDLE stays IDLE.
  - imem_rvalid in the same cycle as redirect is discarded. Any pop that cycle is still counted as accepted by decode.
- Decode handshake:
  - enable_decode = (count>0), registered.
  - insn/pc = head entry; they must stay stable while enable_decode=1 && decode_ready=0.
  - Pop when enable_decode && decode_ready.
- Push and pop in the same cycle: count unchanged. Push into an empty FIFO appears at the outputs the next cycle (response-to-decode latency 1 cycle).
- Full (count=2): no issue. Count<2 holds whenever a response arrives because of the issue rule, so a push never overflows.
- Empty FIFO: insn/pc hold their last values; enable_decode=0.
- Sequential throughput with 1-cycle memory latency: 1 instruction per 2 cycles.
- Reset asserted mid-operation: immediate return to reset values; the outstanding response is ignored because state=IDLE.

Test Plan:
1. Reset release, memory latency 1, decode_ready=1, rdata=addr^32'hFFFF0000 -> imem_req pulses at 0x80020000, 0x80020004, ... every 2 cycles; enable_decode delivers pc=0x80020000 with insn=0x7FFD0000, then pc=0x80020004 in order.
2. decode_ready=0 throughout -> exactly 2 requests; count=2; imem_req stays 0; insn/pc hold the first entry (pc=0x80020000). Raising decode_ready drains both entries in 2 cycles, then fetch resumes at 0x80020008.
3. redirect=1 with redirect_pc=0x80021003 while in WAIT (latency 3) -> late response discarded, enable_decode=0; next imem_req is to 0x80021000 and the delivered pc is 0x80021000.
4. redirect in the same cycle as imem_rvalid -> that word is never delivered; the next fetch is at redirect_pc.
5. redirect_pc=0xFFFFFFFC -> delivered pcs are 0xFFFFFFFC, then 0x00000000.
6. reset_n pulsed low asynchronously mid-WAIT -> outputs immediately zero, enable_decode=0; the stray imem_rvalid is ignored; fetch restarts at RESET_PC.
